// File: rtl/vga_capture_rx_if.sv
// Video-in / decoded-pixel-out bundle for vga_capture_rx.
// The source side drives pix_en/h_sync/v_sync/rgb. The receiver drives everything else.
interface vga_capture_rx_if;
  logic        pix_en;
  logic        h_sync;
  logic        v_sync;
  logic [11:0] rgb;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [11:0] pix_rgb;
  logic        frame_start;
  logic        locked;
  logic        timing_err;
  logic [7:0]  err_count;
  logic [15:0] frame_sum;
  logic        sum_valid;

  modport master (
    output pix_en, h_sync, v_sync, rgb,
    input  pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, timing_err, err_count,
           frame_sum, sum_valid
  );

  modport slave (
    input  pix_en, h_sync, v_sync, rgb,
    output pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, timing_err, err_count,
           frame_sum, sum_valid
  );
endinterface

// File: rtl/vga_capture_rx.sv
// VGA sink: re-derives pixel coordinates from hsync/vsync, checks the timing and locks to it.
// Define VGA_RX_CHECKSUM_EN to get a per-frame RGB checksum on frame_sum/sum_valid.
module vga_capture_rx #(
  parameter int unsigned HActive = 640,
  parameter int unsigned HFp     = 16,
  parameter int unsigned HSync   = 96,
  parameter int unsigned HBp     = 48,
  parameter int unsigned VActive = 480,
  parameter int unsigned VFp     = 10,
  parameter int unsigned VSync   = 2,
  parameter int unsigned VBp     = 33
) (
  input logic             clk,
  input logic             reset,
  vga_capture_rx_if.slave vga_io
);

  localparam int unsigned HTotal = HActive + HFp + HSync + HBp;
  localparam int unsigned VTotal = VActive + VFp + VSync + VBp;

  localparam logic [9:0] HStart = 10'(HSync + HBp);
  localparam logic [9:0] HEnd   = 10'(HSync + HBp + HActive);
  localparam logic [9:0] VStart = 10'(VSync + VBp);
  localparam logic [9:0] VEnd   = 10'(VSync + VBp + VActive);
  localparam logic [9:0] HLast  = 10'(HTotal - 1);
  localparam logic [9:0] HTotC  = 10'(HTotal);
  localparam logic [9:0] VLast  = 10'(VTotal - 1);
  localparam logic [9:0] HSyncC = 10'(HSync);

  typedef enum logic [1:0] {StUnlocked, StMeasure, StLocked} state_e;

  state_e      state_q;
  logic        hs_q, vs_q, skip_q, err_seen_q;
  logic [9:0]  h_cnt_q, v_cnt_q;
  logic        pix_valid_q, frame_start_q, timing_err_q;
  logic [9:0]  pix_x_q;
  logic [8:0]  pix_y_q;
  logic [11:0] pix_rgb_q;
  logic [7:0]  err_count_q;

  logic       tick, hs_fall, hs_rise, vs_fall, checking, err_now, active, pix_hit;
  logic [9:0] h_cnt_inc, v_cnt_inc, h_cnt_d, v_cnt_d;

  always_comb begin
    tick      = vga_io.pix_en;
    hs_fall   = tick & hs_q & ~vga_io.h_sync;
    hs_rise   = tick & ~hs_q & vga_io.h_sync;
    vs_fall   = tick & vs_q & ~vga_io.v_sync;
    h_cnt_inc = (h_cnt_q == 10'h3FF) ? h_cnt_q : h_cnt_q + 10'd1;
    v_cnt_inc = (v_cnt_q == 10'h3FF) ? v_cnt_q : v_cnt_q + 10'd1;
    h_cnt_d   = hs_fall ? 10'd0 : h_cnt_inc;
    v_cnt_d   = vs_fall ? 10'd0 : (hs_fall ? v_cnt_inc : v_cnt_q);
    checking  = (state_q != StUnlocked);
    // A fall clears h_cnt, so a rise always sees the incremented count.
    err_now   = checking & ((hs_fall & ~skip_q & (h_cnt_q != HLast)) |
                            (tick & ~hs_fall & (h_cnt_inc == HTotC)) |
                            (hs_rise & (h_cnt_inc != HSyncC)) |
                            (vs_fall & (v_cnt_q != VLast)));
    active    = (h_cnt_d >= HStart) && (h_cnt_d < HEnd) &&
                (v_cnt_d >= VStart) && (v_cnt_d < VEnd);
    pix_hit   = tick & active & (state_q == StLocked) & ~err_now;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StUnlocked;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      skip_q        <= 1'b0;
      err_seen_q    <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      timing_err_q  <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_rgb_q     <= '0;
      err_count_q   <= '0;
    end else begin
      pix_valid_q   <= pix_hit;
      frame_start_q <= vs_fall;
      timing_err_q  <= err_now;
      if (pix_hit) begin
        pix_x_q   <= h_cnt_d - HStart;
        pix_y_q   <= 9'(v_cnt_d - VStart);
        pix_rgb_q <= vga_io.rgb;
      end
      if (err_now && (err_count_q != 8'hFF)) err_count_q <= err_count_q + 8'd1;
      if (tick) begin
        hs_q    <= vga_io.h_sync;
        vs_q    <= vga_io.v_sync;
        h_cnt_q <= h_cnt_d;
        v_cnt_q <= v_cnt_d;
        if (hs_fall && checking) skip_q <= 1'b0;
        unique case (state_q)
          StUnlocked: begin
            if (vs_fall) begin
              state_q    <= StMeasure;
              skip_q     <= 1'b1;
              err_seen_q <= 1'b0;
            end
          end
          StMeasure: begin
            // An error on the vsync-fall tick belongs to the frame that just ended.
            if (vs_fall) begin
              if (!(err_seen_q || err_now)) state_q <= StLocked;
              err_seen_q <= 1'b0;
            end else if (err_now) begin
              err_seen_q <= 1'b1;
            end
          end
          StLocked: begin
            if (err_now) begin
              state_q    <= StMeasure;
              err_seen_q <= ~vs_fall;
            end
          end
          default: state_q <= StUnlocked;
        endcase
      end
    end
  end

  assign vga_io.pix_valid   = pix_valid_q;
  assign vga_io.pix_x       = pix_x_q;
  assign vga_io.pix_y       = pix_y_q;
  assign vga_io.pix_rgb     = pix_rgb_q;
  assign vga_io.frame_start = frame_start_q;
  assign vga_io.locked      = (state_q == StLocked);
  assign vga_io.timing_err  = timing_err_q;
  assign vga_io.err_count   = err_count_q;

`ifdef VGA_RX_CHECKSUM_EN
  logic [15:0] acc_q, frame_sum_q;
  logic        sum_valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      frame_sum_q <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      sum_valid_q <= 1'b0;
      if (vs_fall) begin
        acc_q <= '0;
        if (state_q == StLocked) begin
          frame_sum_q <= acc_q;
          sum_valid_q <= 1'b1;
        end
      end else if (pix_hit) begin
        acc_q <= acc_q + {4'h0, vga_io.rgb};
      end
    end
  end

  assign vga_io.frame_sum = frame_sum_q;
  assign vga_io.sum_valid = sum_valid_q;
`else
  assign vga_io.frame_sum = 16'h0;
  assign vga_io.sum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_capture_rx.sv
// Directed bench for vga_capture_rx on a shrunken 15x9 raster (8x4 active) to keep runs short.
// Honours VGA_RX_CHECKSUM_EN for the checksum expectations.
module tb_vga_capture_rx;
  localparam int HA = 8, HFP = 2, HS = 3, HBP = 2, HT = HA + HFP + HS + HBP;
  localparam int VA = 4, VFP = 1, VS = 2, VBP = 2, VT = VA + VFP + VS + VBP;
  localparam int HSTART = HS + HBP, VSTART = VS + VBP;

`ifdef VGA_RX_CHECKSUM_EN
  localparam int          EXP_SV = 1;
  localparam logic [15:0] EXP_SUM_WHITE = 16'hFFE0;  // 32 * 0xFFF mod 2^16
  localparam logic [15:0] EXP_SUM_GRAD  = 16'h7770;  // 4 * 0x111 * (0+..+7)
`else
  localparam int          EXP_SV = 0;
  localparam logic [15:0] EXP_SUM_WHITE = 16'h0;
  localparam logic [15:0] EXP_SUM_GRAD  = 16'h0;
`endif

  logic clk, reset;
  vga_capture_rx_if bus ();

  vga_capture_rx #(
    .HActive(HA), .HFp(HFP), .HSync(HS), .HBp(HBP),
    .VActive(VA), .VFp(VFP), .VSync(VS), .VBp(VBP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .vga_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  logic        s_valid, s_fs, s_locked, s_err, s_sv;
  logic [9:0]  s_x;
  logic [8:0]  s_y;
  logic [11:0] s_rgb;
  logic [15:0] s_sum;

  int n_valid, n_err, n_fs, n_sv, n_bad, first_x, first_y, last_x, last_y, err_l, err_k;
  logic locked_first;
  logic [15:0] last_sum;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pixel tick, then sample the registered outputs it produced.
  task automatic tick(input logic h, input logic v, input logic [11:0] c);
    bus.pix_en = 1'b1;
    bus.h_sync = h;
    bus.v_sync = v;
    bus.rgb    = c;
    @(posedge clk); #1;
    bus.pix_en = 1'b0;
    s_valid  = bus.pix_valid;  s_x   = bus.pix_x;     s_y = bus.pix_y;
    s_rgb    = bus.pix_rgb;    s_fs  = bus.frame_start;
    s_locked = bus.locked;     s_err = bus.timing_err;
    s_sv     = bus.sum_valid;  s_sum = bus.frame_sum;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    n_valid = 0; n_err = 0; n_fs = 0; n_sv = 0; n_bad = 0;
    first_x = -1; first_y = -1; last_x = -1; last_y = -1; err_l = -1; err_k = -1;
    locked_first = 1'bx; last_sum = 16'h0;
  endtask

  task automatic note(input int l, input int k, input logic [11:0] c);
    if (s_valid) begin
      n_valid++;
      if (first_x < 0) begin first_x = int'(s_x); first_y = int'(s_y); end
      last_x = int'(s_x); last_y = int'(s_y);
      if (s_x !== 10'(k - HSTART) || s_y !== 9'(l - VSTART) || s_rgb !== c) n_bad++;
    end
    if (s_err) begin
      n_err++;
      if (err_l < 0) begin err_l = l; err_k = k; end
    end
    if (s_fs) n_fs++;
    if (s_sv) begin n_sv++; last_sum = s_sum; end
  endtask

  // mode 0: all white, mode 1: gradient x[3:0] replicated. -1 disables short/nohs/stop.
  task automatic send_frame(input int mode, input int short_l, input int nohs_l,
                            input int stop_l, input int stop_k);
    int len;
    logic h, v, act;
    logic [11:0] c;
    logic [3:0] x4;
    clear_stats();
    for (int l = 0; l < VT; l++) begin
      len = (l == short_l) ? HT - 1 : HT;
      for (int k = 0; k < len; k++) begin
        h   = (l == nohs_l) ? 1'b1 : (k >= HS);
        v   = (l >= VS);
        act = (k >= HSTART) && (k < HSTART + HA) && (l >= VSTART) && (l < VSTART + VA);
        x4  = 4'(k - HSTART);
        c   = (mode == 0) ? 12'hFFF : (act ? {x4, x4, x4} : 12'h000);
        tick(h, v, c);
        if (l == 0 && k == 0) locked_first = s_locked;
        note(l, k, c);
        if (l == stop_l && k == stop_k) return;
      end
    end
  endtask

  // Four-tick lines with a one-tick hsync pulse: bad length and bad pulse width.
  task automatic bad_lines(input int n);
    clear_stats();
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++) begin
        tick(k != 0, 1'b1, 12'h000);
        if (s_err) n_err++;
      end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.pix_en = 1'b0; bus.h_sync = 1'b1; bus.v_sync = 1'b1; bus.rgb = 12'h0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", bus.pix_valid, 0);
    check("rst_locked", bus.locked, 0);
    check("rst_errcnt", bus.err_count, 0);
    check("rst_pixx", bus.pix_x, 0);
    check("rst_fs", bus.frame_start, 0);
    check("rst_terr", bus.timing_err, 0);
    check("rst_sum", bus.frame_sum, 0);
    reset = 1'b0;

    // Two vsync falls to lock; the second frame is fully decoded.
    send_frame(0, -1, -1, -1, -1);
    check("a_valid", n_valid, 0);
    check("a_locked", s_locked, 0);
    send_frame(0, -1, -1, -1, -1);
    check("b_locked_at_vfall", locked_first, 1);
    check("b_valid", n_valid, HA * VA);
    check("b_first", {first_x[15:0], first_y[15:0]}, 0);
    check("b_last", {last_x[15:0], last_y[15:0]}, {16'(HA - 1), 16'(VA - 1)});
    check("b_bad", n_bad, 0);
    check("b_err", n_err, 0);
    check("b_fs", n_fs, 1);

    send_frame(1, -1, -1, -1, -1);
    check("c_valid", n_valid, HA * VA);
    check("c_bad", n_bad, 0);
    check("c_err", n_err, 0);
    check("c_sv", n_sv, EXP_SV);
    check("c_sum", s_sum, EXP_SUM_WHITE);
    check("hold_x", bus.pix_x, HA - 1);
    check("hold_y", bus.pix_y, VA - 1);

    // Line 5 one tick short: error at line 6 start, unlock, one clean frame then relock.
    send_frame(0, 5, -1, -1, -1);
    check("d_err", n_err, 1);
    check("d_err_line", err_l, 6);
    check("d_valid", n_valid, 2 * HA);
    check("d_locked", s_locked, 0);
    check("d_errcnt", bus.err_count, 1);
    check("d_sum", last_sum, EXP_SUM_GRAD);
    send_frame(0, -1, -1, -1, -1);
    check("e_valid", n_valid, 0);
    check("e_locked", s_locked, 0);
    send_frame(0, -1, -1, -1, -1);
    check("f_valid", n_valid, HA * VA);
    check("f_locked", s_locked, 1);

    // Missing hsync on line 2: flagged when h_cnt hits HT, then bad length on line 3.
    send_frame(0, -1, 2, -1, -1);
    check("g_err", n_err, 2);
    check("g_err_pos", {err_l[15:0], err_k[15:0]}, {16'd2, 16'd0});
    check("g_errcnt", bus.err_count, 3);
    check("g_locked", s_locked, 0);
    bad_lines(150);
    check("burst_err", n_err, 299);
    check("burst_sat", bus.err_count, 255);

    send_frame(0, -1, -1, -1, -1);
    check("i_err", n_err, 1);
    check("i_errcnt", bus.err_count, 255);
    // Stop at pixel (3,2) of a locked frame and reset asynchronously.
    send_frame(0, -1, -1, VSTART + 2, HSTART + 3);
    check("j_valid", n_valid, 2 * HA + 4);
    check("j_pix", {6'd0, s_x, 7'd0, s_y}, {6'd0, 10'd3, 7'd0, 9'd2});
    check("j_locked", s_locked, 1);
    #2 reset = 1'b1;
    #1;
    check("async_locked", bus.locked, 0);
    check("async_errcnt", bus.err_count, 0);
    check("async_pixx", bus.pix_x, 0);
    check("async_pixy", bus.pix_y, 0);
    check("async_rgb", bus.pix_rgb, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    send_frame(0, -1, -1, -1, -1);
    check("k1_valid", n_valid, 0);
    send_frame(0, -1, -1, -1, -1);
    check("k2_valid", n_valid, HA * VA);
    check("k2_err", n_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
